// File: rtl/l2_adaptor_pkg.sv
// ---------------------------------------------------------------------------
// l2_adaptor_pkg
// Shared types and constants for the L2 cacheline <-> memory burst adaptor.
//   adaptor_state_t : FSM state encoding (2 bits)
//   line_t / beat_t : full cacheline and single memory beat containers
//   LINE_WIDTH, BURST_WIDTH, BEATS, OFFSET_BITS : geometry of the transfer
// ---------------------------------------------------------------------------
package l2_adaptor_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// l2_cacheline_adaptor
// Sits below the L2 cache controller. Each 256-bit cacheline read or write
// request is turned into a 4-beat, 64-bit burst to physical memory, and a
// single one-cycle resp pulse is returned to the L2 when the burst ends.
//
// Ports
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   L2 side     : line_i (write-back line), line_o (assembled fill line),
//                 address_i, read_i, write_i (levels held until resp_o),
//                 resp_o (one-cycle pulse)
//   Memory side : burst_i (read beat), burst_o (write beat),
//                 address_o (line-aligned), read_o, write_o,
//                 resp_i (per-beat acknowledge)
// ---------------------------------------------------------------------------
module l2_cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // L2 side
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  // Memory side
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  // Derived geometry; deliberately not parameters so they track the widths.
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  import l2_adaptor_pkg::*;

  adaptor_state_t          r_state;
  adaptor_state_t          w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LINE_WIDTH-1:0]   r_wline;
  logic [LINE_WIDTH-1:0]   r_line;
  logic                    w_accept;
  logic                    w_last_beat;

  // A request is only taken from IDLE; DONE never accepts, so the L2 has a
  // cycle to drop its level request after seeing resp.
  assign w_accept    = (r_state == ST_IDLE) && (read_i || write_i);
  assign w_last_beat = resp_i && (r_cnt == LAST_BEAT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    read_o      = 1'b0;
    write_o     = 1'b0;
    resp_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Write-back wins over fill when both are raised together.
        if (write_i) begin
          w_state_nxt = ST_WR_BURST;
        end else if (read_i) begin
          w_state_nxt = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        read_o = 1'b1;
        if (w_last_beat) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR_BURST: begin
        write_o = 1'b1;
        if (w_last_beat) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        resp_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address latch, write-line snapshot, beat counter and fill-line assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_line  <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= {address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        r_cnt  <= '0;
        if (write_i) begin
          r_wline <= line_i;
        end
      end
      if ((r_state == ST_RD_BURST) && resp_i) begin
        r_line[r_cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
      end
      // Counter wraps LAST_BEAT -> 0 only on the terminating beat.
      if (((r_state == ST_RD_BURST) || (r_state == ST_WR_BURST)) && resp_i) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign address_o = r_addr;
  assign line_o    = r_line;
  // Write beat follows the counter directly so a stalled beat stays on the bus.
  assign burst_o   = write_o ? r_wline[r_cnt*BURST_WIDTH +: BURST_WIDTH] : '0;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  l2_cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_resp_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_rd;
    logic [255:0] line;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Drives one L2 request, checks every burst cycle against the bench's own
  // view of the transfer, then checks the resp cycle against the scoreboard.
  task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input logic [15:0] pat, input int plen, output int ncyc);
    int k;
    int i;
    exp_t e;
    bit is_wr;
    logic [31:0] exp_addr;
    is_wr    = wr;
    exp_addr = {addr[31:5], 5'b0};
    @(negedge clk);
    chk("pre_idle_resp", resp_o, 1'b0);
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = wline;
    resp_i    = 1'b0;
    e.is_rd   = !is_wr;
    e.line    = rline;
    sb.push_back(e);
    k = 0;
    i = 0;
    ncyc = 0;
    while (k < 4) begin
      @(negedge clk);
      ncyc++;
      if (ncyc > 60) begin
        chk("timeout", 1'b0, 1'b1);
        break;
      end
      chk("read_o", read_o, !is_wr);
      chk("write_o", write_o, is_wr);
      chk("resp_mid", resp_o, 1'b0);
      chk("address_o", address_o, exp_addr);
      if (is_wr) chk("burst_o", burst_o, wline[64*k +: 64]);
      // Request side scribbles mid-burst; the adaptor must ignore it.
      address_i = $urandom;
      line_i    = {8{$urandom}};
      resp_i    = (i < plen) ? pat[i] : 1'b1;
      burst_i   = rline[64*k +: 64];
      i++;
      if (resp_i) k++;
    end
    @(negedge clk);
    resp_i = 1'b0;
    chk("resp_o", resp_o, 1'b1);
    chk("read_o_done", read_o, 1'b0);
    chk("write_o_done", write_o, 1'b0);
    if (resp_o === 1'b1) begin
      if (sb.size() == 0) chk("sb_empty", 1'b0, 1'b1);
      else begin
        e = sb.pop_front();
        if (e.is_rd) chk("line_o", line_o, e.line);
      end
    end
    if (last_resp_cyc >= 0) chk("resp_gap", (cyc - last_resp_cyc) >= 5, 1'b1);
    last_resp_cyc = cyc;
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  logic [255:0] rl1, wl1, wl2, rl2, rl3, held;
  int n;

  initial begin
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_address_o", address_o, 32'h0);
    chk("rst_burst_o", burst_o, 64'h0);
    chk("rst_line_o", line_o, 256'h0);
    rst = 1'b0;

    // Read, back-to-back beats.
    rl1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_req(1'b1, 1'b0, 32'h0000_1234, '0, rl1, 16'hFFFF, 4, n);
    chk("rd_cycles", n, 4);

    // Write with stalls: resp_i 1,0,0,1,1,0,1.
    wl1 = {64'hD3D3_0003_3333_0003, 64'hD2D2_0002_2222_0002,
           64'hD1D1_0001_1111_0001, 64'hD0D0_0000_0000_0000};
    run_req(1'b0, 1'b1, 32'hABCD_EF1F, wl1, '0, 16'h0059, 7, n);
    chk("wr_cycles", n, 7);

    // Read and write raised together: write wins.
    wl2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'h5555_AAAA_5555_AAAA, 64'hDEAD_BEEF_CAFE_F00D};
    run_req(1'b1, 1'b1, 32'h8000_0040, wl2, '0, 16'h0005, 4, n);

    // resp_i toggling in IDLE with no request does nothing.
    @(negedge clk);
    held   = line_o;
    resp_i = 1'b1;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("idle_resp_o", resp_o, 1'b0);
      chk("idle_read_o", read_o, 1'b0);
      chk("idle_write_o", write_o, 1'b0);
      chk("idle_line_o", line_o, held);
    end
    resp_i = 1'b0;

    // Back-to-back: write then read right after its resp.
    run_req(1'b0, 1'b1, 32'h0000_2000, wl2, '0, 16'hFFFF, 4, n);
    rl2 = {64'h9999_0000_9999_0003, 64'h8888_0000_8888_0002,
           64'h7777_0000_7777_0001, 64'h6666_0000_6666_0000};
    run_req(1'b1, 1'b0, 32'h0000_3FFF, '0, rl2, 16'hFFFF, 4, n);

    // Async reset in the middle of a read after two beats.
    @(negedge clk);
    read_i    = 1'b1;
    address_i = 32'h0000_5000;
    @(negedge clk);
    resp_i  = 1'b1;
    burst_i = 64'h1111_2222_3333_4444;
    @(negedge clk);
    burst_i = 64'h5555_6666_7777_8888;
    @(negedge clk);
    resp_i = 1'b0;
    chk("mid_read_o", read_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_read_o", read_o, 1'b0);
    chk("arst_write_o", write_o, 1'b0);
    chk("arst_resp_o", resp_o, 1'b0);
    chk("arst_address_o", address_o, 32'h0);
    chk("arst_line_o", line_o, 256'h0);
    chk("arst_burst_o", burst_o, 64'h0);
    read_i = 1'b0;
    #1 rst = 1'b0;
    rl3 = {64'hC0C0_C0C0_0000_0003, 64'hB0B0_B0B0_0000_0002,
           64'hA0A0_A0A0_0000_0001, 64'hF0F0_F0F0_0000_0000};
    run_req(1'b1, 1'b0, 32'h0000_6020, '0, rl3, 16'h0006, 4, n);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
